// File: rtl/fp_add_initiator.sv
// In-order result queue for fp_add_initiator; plain circular buffer, no bypass.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the owner never pushes when full or pops when empty.
module fp_add_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Drives one FP32 adder operation at a time over En/Ready and queues tagged results.
// Latency: accept at cycle 0, add_en at cycle 1, result visible the cycle after add_ready.
// Backpressure: cmd_ready only in IDLE with a free result slot; res_ready stalls the queue.
module fp_add_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_sub,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_en,
  input  logic [31:0]      add_sum,
  input  logic             add_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             busy,
  output logic             err_stray
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } res_t;

  state_t           state;
  logic [TAG_W-1:0] tag_q;
  logic [WD_W-1:0]  wd;
  logic [CW-1:0]    count;
  logic             accept;
  logic             wd_expired;
  logic             push;
  logic             pop;
  res_t             push_dat;
  res_t             head;

  // A slot is reserved at accept time, so the push at WAIT exit always fits.
  assign cmd_ready  = !reset && (state == IDLE) && (count < CW'(FIFO_DEPTH));
  assign accept     = cmd_valid && cmd_ready;
  assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign push       = (state == WAIT) && (add_ready || wd_expired);
  assign push_dat   = '{data: add_ready ? add_sum : 32'h0, tag: tag_q, timeout: !add_ready};
  assign res_valid  = (count != '0);
  assign pop        = res_valid && res_ready;
  assign busy       = (state != IDLE);

  // Head is masked when empty so the unreset storage never leaks out.
  assign res_data    = res_valid ? head.data    : 32'h0;
  assign res_tag     = res_valid ? head.tag     : '0;
  assign res_timeout = res_valid ? head.timeout : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      add_a     <= 32'h0;
      add_b     <= 32'h0;
      add_en    <= 1'b0;
      tag_q     <= '0;
      wd        <= '0;
      err_stray <= 1'b0;
    end else begin
      if (add_ready && (state != WAIT))
        err_stray <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            add_a <= cmd_a;
            // Negating +0 would turn it into -0 and defeat the adder's zero shortcut.
            add_b  <= (cmd_sub && (cmd_b != 32'h0)) ? {~cmd_b[31], cmd_b[30:0]} : cmd_b;
            tag_q  <= cmd_tag;
            add_en <= 1'b1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          add_en <= 1'b0;
          wd     <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (add_ready || wd_expired)
            state <= IDLE;
          else
            wd <= wd + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fp_add_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );
endmodule

// File: tb/tb_fp_add_initiator.sv
// Bench for fp_add_initiator: adder stub with programmable response delay plus a result scoreboard.
module tb_fp_add_initiator;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int TAG_W          = 4;
  localparam int N_RAND         = 30;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_a = 32'h0;
  logic [31:0]      cmd_b = 32'h0;
  logic             cmd_sub = 1'b0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_en;
  logic [31:0]      add_sum = 32'h0;
  logic             add_ready = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;
  logic             busy;
  logic             err_stray;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    logic             to;
  } exp_t;

  always #5 clk = ~clk;

  fp_add_initiator #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TAG_W          (TAG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sub     (cmd_sub),
    .cmd_tag     (cmd_tag),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_en      (add_en),
    .add_sum     (add_sum),
    .add_ready   (add_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_timeout (res_timeout),
    .busy        (busy),
    .err_stray   (err_stray)
  );

  // Adder stand-in: the known test-plan sums, otherwise an arbitrary mix of A and B.
  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'hBF800000}: return 32'h40000000;
      {32'h40A00000, 32'h00000000}: return 32'h40A00000;
      default:                      return (a ^ {b[15:0], b[31:16]}) + 32'h1;
    endcase
  endfunction

  function automatic logic [31:0] exp_b(input logic [31:0] b, input logic sub);
    if (sub && (b != 32'h0)) return b ^ 32'h8000_0000;
    return b;
  endfunction

  bit stub_on    = 1'b1;
  int stub_delay = 2;
  int stray_cnt  = 0;
  int stray_done = 0;
  bit pending    = 1'b0;
  int cnt        = 0;

  always @(negedge clk) begin
    add_ready = 1'b0;
    if (reset) begin
      pending = 1'b0;
    end else if (stray_cnt != stray_done) begin
      add_ready  = 1'b1;
      stray_done = stray_done + 1;
    end else if (add_en) begin
      pending = stub_on;
      cnt     = stub_delay;
    end else if (pending) begin
      if (cnt == 0) begin
        add_ready = 1'b1;
        add_sum   = stub_sum(add_a, add_b);
        pending   = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  // Presents a command and returns at the negedge of the LAUNCH cycle.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [TAG_W-1:0] tag);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sub = sub; cmd_tag = tag;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_cmd tag=%0d: cmd_ready=%b, required 1 within 500 cycles", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, add_en, res_valid, busy, err_stray, res_timeout} !== 6'b0 ||
        add_a !== 32'h0 || add_b !== 32'h0 || res_data !== 32'h0 || res_tag !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b en=%b rv=%b busy=%b err=%b a=%h b=%h d=%h, required all 0",
               cmd_ready, add_en, res_valid, busy, err_stray, add_a, add_b, res_data);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_add_sub;
    logic [31:0]      va  [3] = '{32'h3F800000, 32'h40400000, 32'h40A00000};
    logic [31:0]      vb  [3] = '{32'h40000000, 32'h3F800000, 32'h00000000};
    logic             vs  [3] = '{1'b0, 1'b1, 1'b1};
    logic [TAG_W-1:0] vt  [3] = '{4'd3, 4'd6, 4'd10};
    logic [31:0]      veb [3] = '{32'h40000000, 32'hBF800000, 32'h00000000};
    logic [31:0]      vr  [3] = '{32'h40400000, 32'h40000000, 32'h40A00000};
    for (int i = 0; i < 3; i++) begin
      int lat = 0;
      bit held = 1'b1;
      bit en_ok = 1'b1;
      stub_on = 1'b1;
      stub_delay = 3;
      send_cmd(va[i], vb[i], vs[i], vt[i]);
      tests++;
      if (add_en !== 1'b1 || add_a !== va[i] || add_b !== veb[i]) begin
        fails++;
        $display("FAIL launch_%0d: en=%b a=%h b=%h, required 1 %h %h", i, add_en, add_a, add_b, va[i], veb[i]);
      end
      do begin
        @(negedge clk);
        lat++;
        if (add_en !== 1'b0) en_ok = 1'b0;
        if (busy && (add_a !== va[i] || add_b !== veb[i])) held = 1'b0;
      end while (res_valid !== 1'b1 && lat < 200);
      tests++;
      if (!held || !en_ok) begin
        fails++;
        $display("FAIL hold_%0d: operands_held=%b en_single_pulse=%b, required 1 1", i, held, en_ok);
      end
      tests++;
      if (lat != stub_delay + 2) begin
        fails++;
        $display("FAIL latency_%0d: %0d cycles launch-to-res_valid, required %0d", i, lat, stub_delay + 2);
      end
      tests++;
      if (res_data !== vr[i] || res_tag !== vt[i] || res_timeout !== 1'b0) begin
        fails++;
        $display("FAIL result_%0d: data=%h tag=%0d to=%b, required %h %0d 0",
                 i, res_data, res_tag, res_timeout, vr[i], vt[i]);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      tests++;
      if (res_valid !== 1'b0) begin
        fails++;
        $display("FAIL pop_%0d: res_valid=%b, required 0", i, res_valid);
      end
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    stub_on = 1'b0;
    send_cmd(32'h12345678, 32'h9ABCDEF0, 1'b0, 4'd7);
    @(negedge clk);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != TIMEOUT_CYCLES) begin
      fails++;
      $display("FAIL timeout_cycles: %0d cycles in WAIT, required %0d", n, TIMEOUT_CYCLES);
    end
    tests++;
    if (res_valid !== 1'b1 || res_data !== 32'h0 || res_timeout !== 1'b1 || res_tag !== 4'd7 || err_stray !== 1'b0) begin
      fails++;
      $display("FAIL timeout_result: rv=%b data=%h to=%b tag=%0d err=%b, required 1 0 1 7 0",
               res_valid, res_data, res_timeout, res_tag, err_stray);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    stray_cnt++;
    repeat (3) @(negedge clk);
    tests++;
    if (err_stray !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL late_ready: err_stray=%b res_valid=%b busy=%b, required 1 0 0", err_stray, res_valid, busy);
    end
    stub_on = 1'b1;
  endtask

  task automatic test_fifo_full;
    bit stall_ok = 1'b1;
    res_ready = 1'b0;
    stub_on = 1'b1;
    stub_delay = 1;
    for (int t = 1; t <= 4; t++) begin
      int n = 0;
      send_cmd($urandom, $urandom, 1'b0, TAG_W'(t));
      while (busy && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    cmd_valid = 1'b1; cmd_a = 32'h11111111; cmd_b = 32'h22222222; cmd_sub = 1'b0; cmd_tag = 4'd5;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b1) stall_ok = 1'b0;
    end
    tests++;
    if (!stall_ok || res_tag !== 4'd1) begin
      fails++;
      $display("FAIL full_stall: stalled=%b head_tag=%0d, required 1 1", stall_ok, res_tag);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || res_tag !== 4'd2) begin
      fails++;
      $display("FAIL slot_freed: cmd_ready=%b head_tag=%0d, required 1 2", cmd_ready, res_tag);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if (add_en !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL accept_5: add_en=%b busy=%b, required 1 1", add_en, busy);
    end
    // Delay 1: Ready lands two cycles after LAUNCH; pop in that same cycle.
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (busy !== 1'b0 || res_tag !== 4'd3) begin
      fails++;
      $display("FAIL push_pop: busy=%b head_tag=%0d, required 0 3", busy, res_tag);
    end
    for (int k = 3; k <= 5; k++) begin
      tests++;
      if (res_valid !== 1'b1 || res_tag !== TAG_W'(k) || res_timeout !== 1'b0) begin
        fails++;
        $display("FAIL order_%0d: rv=%b tag=%0d to=%b, required 1 %0d 0", k, res_valid, res_tag, res_timeout, k);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL drained: res_valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit quiet = 1'b1;
    stub_on = 1'b1;
    stub_delay = 10;
    send_cmd(32'h3F800000, 32'h3F800000, 1'b0, 4'd9);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || add_en !== 1'b0 || err_stray !== 1'b0 ||
        cmd_ready !== 1'b0 || add_a !== 32'h0) begin
      fails++;
      $display("FAIL reset_abort: busy=%b rv=%b en=%b err=%b rdy=%b a=%h, required 0 0 0 0 0 0",
               busy, res_valid, add_en, err_stray, cmd_ready, add_a);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || err_stray !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL aborted_result: quiet=%b, required 1 (no result, no stray)", quiet);
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    int   got = 0;
    fork
      begin : producer
        logic [31:0]      a, b, eb;
        logic             sub;
        logic [TAG_W-1:0] tag;
        exp_t             e;
        for (int i = 0; i < N_RAND; i++) begin
          int n = 0;
          while (busy && n < 1000) begin
            @(negedge clk);
            n++;
          end
          a   = $urandom;
          b   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          sub = 1'($urandom_range(0, 1));
          tag = TAG_W'($urandom);
          stub_on    = ($urandom_range(0, 7) != 0);
          stub_delay = $urandom_range(0, 6);
          eb = exp_b(b, sub);
          e.d  = stub_on ? stub_sum(a, eb) : 32'h0;
          e.t  = tag;
          e.to = !stub_on;
          q.push_back(e);
          send_cmd(a, b, sub, tag);
          tests++;
          if (add_en !== 1'b1 || add_a !== a || add_b !== eb) begin
            fails++;
            $display("FAIL rand_launch_%0d: en=%b a=%h b=%h, required 1 %h %h", i, add_en, add_a, add_b, a, eb);
          end
        end
      end
      begin : consumer
        exp_t h;
        bit   r;
        int   cyc = 0;
        while (got < N_RAND && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          r = 1'($urandom_range(0, 1));
          if (r && res_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
              fails++;
              $display("FAIL rand_extra: tag=%0d appeared, required no result", res_tag);
            end else begin
              h = q.pop_front();
              if (res_data !== h.d || res_tag !== h.t || res_timeout !== h.to) begin
                fails++;
                $display("FAIL rand_result_%0d: data=%h tag=%0d to=%b, required %h %0d %b",
                         got, res_data, res_tag, res_timeout, h.d, h.t, h.to);
              end
            end
            got++;
          end
          res_ready = r;
        end
        @(negedge clk);
        res_ready = 1'b0;
      end
    join
    tests++;
    if (got != N_RAND || q.size() != 0) begin
      fails++;
      $display("FAIL rand_count: %0d results, %0d still expected, required %0d and 0", got, q.size(), N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_timeout();
    test_fifo_full();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end
endmodule
